// File: rtl/acc_feeder.sv
// Streams N operand words from a read port into an external accumulator and captures the final sum.
// Optional DRAIN watchdog enabled by defining ACC_FEEDER_TIMEOUT_EN.
module acc_feeder #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 32,
  parameter int unsigned AWIDTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [AWIDTH-1:0]        num_cnt_i,
  output logic                     rd_en_o,
  output logic [AWIDTH-1:0]        rd_addr_o,
  input  logic [IN_DATA_WIDTH-1:0] rd_data_i,
  output logic                     acc_run_o,
  output logic                     acc_valid_o,
  output logic [IN_DATA_WIDTH-1:0] acc_number_o,
  input  logic                     acc_valid_i,
  input  logic [DWIDTH-1:0]        acc_result_i,
  output logic                     idle_o,
  output logic                     done_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic                     error_o
);

  localparam int unsigned CW = AWIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [AWIDTH-1:0]   r_num, w_num_nxt;
  logic [AWIDTH-1:0]   r_rd_addr, w_rd_addr_nxt;
  logic [AWIDTH-1:0]   r_ret_cnt, w_ret_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic                r_acc_run, w_acc_run_nxt;
  logic                r_acc_valid;
  logic                r_done, w_done_nxt;
  logic                r_idle;
  logic [DWIDTH-1:0]   r_result, w_result_nxt;
  logic                w_tick;
  logic                w_last_tick;
  logic [AWIDTH:0]     w_ret_inc;

`ifdef ACC_FEEDER_TIMEOUT_EN
  localparam int unsigned WDW = 4;
  logic [WDW-1:0]      r_wdog, w_wdog_nxt;
  logic                r_error, w_error_nxt;
`endif

  // Result ticks only count while a job is streaming or draining.
  assign w_tick      = acc_valid_i && ((r_state == S_READ) || (r_state == S_DRAIN));
  assign w_ret_inc   = {1'b0, r_ret_cnt} + CW'(1);
  assign w_last_tick = w_tick && (w_ret_inc == {1'b0, r_num});

  always_comb begin
    w_state_nxt   = r_state;
    w_num_nxt     = r_num;
    w_rd_addr_nxt = r_rd_addr;
    w_ret_nxt     = r_ret_cnt;
    w_rd_en_nxt   = 1'b0;
    w_acc_run_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_result_nxt  = r_result;
`ifdef ACC_FEEDER_TIMEOUT_EN
    w_wdog_nxt    = r_wdog;
    w_error_nxt   = r_error;
`endif

    if (w_tick) begin
      w_ret_nxt = r_ret_cnt + AWIDTH'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_num_nxt     = num_cnt_i;
          w_rd_addr_nxt = '0;
          w_ret_nxt     = '0;
          w_acc_run_nxt = 1'b1;
          w_state_nxt   = S_CLEAR;
`ifdef ACC_FEEDER_TIMEOUT_EN
          w_error_nxt   = 1'b0;
`endif
        end
      end

      S_CLEAR: begin
        if (r_num != '0) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = '0;
          w_state_nxt   = S_READ;
        end else begin
          w_result_nxt  = '0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = S_DONE;
        end
      end

      S_READ: begin
        if (w_last_tick) begin
          w_result_nxt  = acc_result_i;
          w_done_nxt    = 1'b1;
          w_rd_addr_nxt = '0;
          w_state_nxt   = S_DONE;
        end else if (r_rd_addr == (r_num - AWIDTH'(1))) begin
          w_rd_addr_nxt = '0;
          w_state_nxt   = S_DRAIN;
`ifdef ACC_FEEDER_TIMEOUT_EN
          w_wdog_nxt    = '0;
`endif
        end else begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_rd_addr + AWIDTH'(1);
        end
      end

      S_DRAIN: begin
        if (w_last_tick) begin
          w_result_nxt = acc_result_i;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_DONE;
        end
`ifdef ACC_FEEDER_TIMEOUT_EN
        // Sixteen silent cycles abort the job without touching the held result.
        else if (w_tick) begin
          w_wdog_nxt = '0;
        end else if (r_wdog == WDW'(15)) begin
          w_error_nxt = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_wdog_nxt = r_wdog + WDW'(1);
        end
`endif
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_rd_addr   <= '0;
      r_ret_cnt   <= '0;
      r_rd_en     <= 1'b0;
      r_acc_run   <= 1'b0;
      r_acc_valid <= 1'b0;
      r_done      <= 1'b0;
      r_idle      <= 1'b1;
      r_result    <= '0;
`ifdef ACC_FEEDER_TIMEOUT_EN
      r_wdog      <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_num       <= w_num_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_ret_cnt   <= w_ret_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_acc_run   <= w_acc_run_nxt;
      r_acc_valid <= r_rd_en;
      r_done      <= w_done_nxt;
      r_idle      <= (w_state_nxt == S_IDLE);
      r_result    <= w_result_nxt;
`ifdef ACC_FEEDER_TIMEOUT_EN
      r_wdog      <= w_wdog_nxt;
      r_error     <= w_error_nxt;
`endif
    end
  end

  assign rd_en_o      = r_rd_en;
  assign rd_addr_o    = r_rd_addr;
  assign acc_run_o    = r_acc_run;
  assign acc_valid_o  = r_acc_valid;
  // Read data lands one cycle after the strobe, aligned with the registered valid.
  assign acc_number_o = r_acc_valid ? rd_data_i : '0;
  assign idle_o       = r_idle;
  assign done_o       = r_done;
  assign result_o     = r_result;
`ifdef ACC_FEEDER_TIMEOUT_EN
  assign error_o      = r_error;
`else
  assign error_o      = 1'b0;
`endif

endmodule
